// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared state encoding, access sizes and funct3 codes for the LSU
package load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} lsu_state_t;
  localparam logic [1:0] OPLEN_BYTE = 2'b00;
  localparam logic [1:0] OPLEN_HALF = 2'b01;
  localparam logic [1:0] OPLEN_WORD = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Stores only have the signed-looking byte/half/word encodings
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (!store && ((f3 == F3_LBU) || (f3 == F3_LHU)));
  endfunction
endpackage

// File: rtl/load_store_unit_extend.sv
// lsu_extend: sign/zero extension of right-aligned load data by funct3
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  // Byte/half loads extend from bit 7/15; anything else passes the word through
  assign data = func3 == F3_LB  ? {{24{raw[7]}}, raw[7:0]} :
                func3 == F3_LH  ? {{16{raw[15]}}, raw[15:0]} :
                func3 == F3_LBU ? {24'b0, raw[7:0]} :
                func3 == F3_LHU ? {16'b0, raw[15:0]} : raw;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store issue to the SDRAM data port; LOAD_STORE_UNIT_MISALIGN_TRAP_EN makes misaligned accesses error instead of being force-aligned
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [1:0]        mem_oplen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);
  lsu_state_t        state;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              first_q;
  logic [31:0]       ea;
  logic [31:0]       ext;
  logic [31:0]       wdata_al;
  logic [ADDR_W-1:0] addr_al;
  logic              half;
  logic              word;
  logic              bad;
  logic              unused_ea_hi;
  assign ea           = req_base + req_imm;
  assign unused_ea_hi = ^ea[31:ADDR_W];
  assign half         = req_func3[1:0] == OPLEN_HALF;
  assign word         = req_func3[1:0] == OPLEN_WORD;
  assign wdata_al     = req_func3[1:0] == OPLEN_BYTE ? {24'b0, req_wdata[7:0]} :
                        half ? {16'b0, req_wdata[15:0]} : req_wdata;
`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
  assign bad     = !f3_legal(req_store, req_func3) || (half && ea[0]) || (word && |ea[1:0]);
  assign addr_al = ea[ADDR_W-1:0];
`else
  assign bad     = !f3_legal(req_store, req_func3);
  assign addr_al = {ea[ADDR_W-1:2], ea[1] & ~word, ea[0] & ~(half | word)};
`endif
  assign busy      = state != IDLE;
  assign req_ready = state == IDLE;
  lsu_extend u_ext (
    .func3(f3_q),
    .raw  (mem_rdata),
    .data (ext)
  );
  // Request accept, one-shot port issue, completion capture and response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      f3_q       <= 3'b0;
      rd_q       <= 5'b0;
      first_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rd    <= 5'b0;
      resp_data  <= 32'b0;
      resp_err   <= 1'b0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_oplen  <= 2'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      mem_enable <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          store_q <= req_store;
          f3_q    <= req_func3;
          rd_q    <= req_rd;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rd    <= req_rd;
            resp_data  <= 32'b0;
          end else begin
            state      <= ISSUE;
            mem_enable <= mem_valid;
            mem_rw     <= ~req_store;
            mem_oplen  <= req_func3[1:0];
            mem_addr   <= addr_al;
            mem_wdata  <= wdata_al;
          end
        end
        ISSUE: if (mem_enable) begin
          state   <= WAIT;
          first_q <= 1'b1;
        end else begin
          mem_enable <= mem_valid;
        end
        WAIT: if (first_q) begin
          first_q <= 1'b0;
        end else if (mem_valid) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rd    <= rd_q;
          resp_we    <= ~store_q & |rd_q;
          resp_data  <= store_q ? 32'b0 : ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load/store issue, extension, errors, stalls and reset abort
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_func3 = 3'b0;
  logic [31:0] req_base = 32'b0;
  logic [31:0] req_imm = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic [4:0]  req_rd = 5'b0;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_oplen;
  logic [24:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid = 1'b1;
  logic [31:0] mem_rdata = 32'b0;
  int tests = 0;
  int fails = 0;
  int en_cnt, en_cyc, r_cyc, seen;
  logic [24:0] o_addr;
  logic [1:0]  o_oplen;
  logic        o_rw, r_we, r_err, post_valid, post_ready, timeout;
  logic [31:0] o_wdata, r_data;
  logic [4:0]  r_rd;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_func3(req_func3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_we(resp_we),
    .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_oplen(mem_oplen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One request from an IDLE slot; the port stays busy for idelay cycles, then completes n cycles into WAIT
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd, input int idelay, input int n, input logic [31:0] rdata);
    int e;
    e = -1; en_cnt = 0; en_cyc = -1; r_cyc = -1;
    req_valid = 1'b1; req_store = st; req_func3 = f3; req_base = base; req_imm = imm; req_wdata = wd; req_rd = rd;
    mem_valid = (idelay == 0); mem_rdata = 32'hA5A5A5A5;
    for (int c = 1; c <= 60 && r_cyc < 0; c++) begin
      step();
      req_valid = 1'b0;
      if (mem_enable) begin
        en_cnt++;
        if (e < 0) begin
          e = c; en_cyc = c; o_addr = mem_addr; o_oplen = mem_oplen; o_rw = mem_rw; o_wdata = mem_wdata;
        end
      end
      if (resp_valid) begin
        r_cyc = c; r_data = resp_data; r_we = resp_we; r_err = resp_err; r_rd = resp_rd;
      end
      mem_valid = (e < 0) ? (c >= idelay) : (c == e + 1 || c >= e + n);
      mem_rdata = (e >= 0 && c >= e + n) ? rdata : 32'hA5A5A5A5;
    end
    timeout = (r_cyc < 0);
    step();
    post_valid = resp_valid; post_ready = req_ready; mem_valid = 1'b1;
  endtask
  task automatic test_reset();
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if ({busy, resp_valid, mem_enable, resp_we, resp_err} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {busy, resp_valid, mem_enable, resp_we, resp_err}); end
    tests++; if ({mem_addr, mem_wdata, resp_data} !== 89'b0) begin fails++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, resp_data}); end
    step(); step(); #2 rst_n = 1'b1;
    step();
  endtask
  task automatic test_lw();
    run_req(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 0, 2, 32'hDEADBEEF);
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL lw_timeout got %b exp 0", timeout); end
    tests++; if (en_cyc != 1 || en_cnt != 1) begin fails++; $display("FAIL lw_enable cyc %0d cnt %0d exp 1 1", en_cyc, en_cnt); end
    tests++; if ({o_addr, o_oplen, o_rw} !== {25'h104, 2'b10, 1'b1}) begin fails++; $display("FAIL lw_port got %h %b %b exp 104 10 1", o_addr, o_oplen, o_rw); end
    tests++; if (r_cyc != 4) begin fails++; $display("FAIL lw_latency got %0d exp 4", r_cyc); end
    tests++; if ({r_data, r_we, r_err, r_rd} !== {32'hDEADBEEF, 1'b1, 1'b0, 5'd5}) begin fails++; $display("FAIL lw_resp got %h %b %b %0d exp deadbeef 1 0 5", r_data, r_we, r_err, r_rd); end
    tests++; if ({post_valid, post_ready} !== 2'b01) begin fails++; $display("FAIL lw_after got %b exp 01", {post_valid, post_ready}); end
  endtask
  task automatic test_extend();
    run_req(1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd7, 0, 2, 32'h00000080);
    tests++; if ({o_addr, o_oplen, r_data} !== {25'h203, 2'b00, 32'hFFFFFF80}) begin fails++; $display("FAIL lb got %h %b %h exp 203 00 ffffff80", o_addr, o_oplen, r_data); end
    run_req(1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd7, 0, 2, 32'h00000080);
    tests++; if (r_data !== 32'h00000080) begin fails++; $display("FAIL lbu got %h exp 00000080", r_data); end
    run_req(1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 5'd7, 0, 2, 32'h1234567F);
    tests++; if (r_data !== 32'h0000007F) begin fails++; $display("FAIL lb_pos got %h exp 0000007f", r_data); end
    run_req(1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 5'd9, 0, 4, 32'h00018000);
    tests++; if ({o_addr, o_oplen, r_data} !== {25'h202, 2'b01, 32'hFFFF8000}) begin fails++; $display("FAIL lh got %h %b %h exp 202 01 ffff8000", o_addr, o_oplen, r_data); end
    tests++; if (r_cyc != 6) begin fails++; $display("FAIL lh_latency got %0d exp 6", r_cyc); end
    run_req(1'b0, 3'b101, 32'h200, 32'h2, 32'h0, 5'd9, 0, 2, 32'h00018000);
    tests++; if (r_data !== 32'h00008000) begin fails++; $display("FAIL lhu got %h exp 00008000", r_data); end
    run_req(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 5'd0, 0, 2, 32'h11223344);
    tests++; if ({r_we, r_data} !== {1'b0, 32'h11223344}) begin fails++; $display("FAIL lw_rd0 got %b %h exp 0 11223344", r_we, r_data); end
  endtask
  task automatic test_store();
    run_req(1'b1, 3'b001, 32'h10, 32'hFFFFFFFE, 32'h12345678, 5'd3, 0, 2, 32'hFFFFFFFF);
    tests++; if ({o_addr, o_oplen, o_rw, o_wdata} !== {25'h0E, 2'b01, 1'b0, 32'h00005678}) begin fails++; $display("FAIL sh_port got %h %b %b %h exp 0e 01 0 00005678", o_addr, o_oplen, o_rw, o_wdata); end
    tests++; if ({r_we, r_err, r_data} !== {1'b0, 1'b0, 32'h0}) begin fails++; $display("FAIL sh_resp got %b %b %h exp 0 0 0", r_we, r_err, r_data); end
    run_req(1'b1, 3'b000, 32'h20, 32'h1, 32'hAABBCCDD, 5'd3, 0, 2, 32'h0);
    tests++; if ({o_addr, o_oplen, o_wdata} !== {25'h21, 2'b00, 32'h000000DD}) begin fails++; $display("FAIL sb_port got %h %b %h exp 21 00 000000dd", o_addr, o_oplen, o_wdata); end
    run_req(1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 5'd3, 0, 3, 32'h0);
    tests++; if ({o_addr, o_oplen, o_wdata, r_cyc[7:0]} !== {25'h40, 2'b10, 32'hCAFEF00D, 8'd5}) begin fails++; $display("FAIL sw got %h %b %h %0d exp 40 10 cafef00d 5", o_addr, o_oplen, o_wdata, r_cyc); end
  endtask
  task automatic test_misalign();
    run_req(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd4, 0, 2, 32'h87654321);
`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
    tests++; if ({r_cyc[7:0], en_cnt[7:0], r_err, r_we} !== {8'd1, 8'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL lw_misalign got cyc %0d en %0d err %b we %b exp 1 0 1 0", r_cyc, en_cnt, r_err, r_we); end
`else
    tests++; if ({o_addr, r_err, r_data} !== {25'h100, 1'b0, 32'h87654321}) begin fails++; $display("FAIL lw_misalign got %h %b %h exp 100 0 87654321", o_addr, r_err, r_data); end
`endif
    run_req(1'b1, 3'b001, 32'h203, 32'h0, 32'h0000BEEF, 5'd4, 0, 2, 32'h0);
`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
    tests++; if ({r_cyc[7:0], en_cnt[7:0], r_err} !== {8'd1, 8'd0, 1'b1}) begin fails++; $display("FAIL sh_misalign got cyc %0d en %0d err %b exp 1 0 1", r_cyc, en_cnt, r_err); end
`else
    tests++; if ({o_addr, r_err} !== {25'h202, 1'b0}) begin fails++; $display("FAIL sh_misalign got %h %b exp 202 0", o_addr, r_err); end
`endif
  endtask
  task automatic test_illegal();
    run_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd6, 0, 2, 32'h0);
    tests++; if ({r_cyc[7:0], en_cnt[7:0], r_err, r_we, r_rd} !== {8'd1, 8'd0, 1'b1, 1'b0, 5'd6}) begin fails++; $display("FAIL ld_f3_011 got cyc %0d en %0d err %b we %b rd %0d exp 1 0 1 0 6", r_cyc, en_cnt, r_err, r_we, r_rd); end
    run_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd6, 0, 2, 32'h0);
    tests++; if ({r_cyc[7:0], en_cnt[7:0], r_err} !== {8'd1, 8'd0, 1'b1}) begin fails++; $display("FAIL st_f3_100 got cyc %0d en %0d err %b exp 1 0 1", r_cyc, en_cnt, r_err); end
    run_req(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 5'd6, 0, 2, 32'h0);
    tests++; if ({r_cyc[7:0], r_err} !== {8'd1, 1'b1}) begin fails++; $display("FAIL ld_f3_110 got cyc %0d err %b exp 1 1", r_cyc, r_err); end
  endtask
  task automatic test_stall();
    run_req(1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 5'd2, 5, 2, 32'h00000001);
    tests++; if (en_cnt != 1 || en_cyc != 6) begin fails++; $display("FAIL stall_enable got cnt %0d cyc %0d exp 1 6", en_cnt, en_cyc); end
    tests++; if (r_cyc != 9 || r_data !== 32'h1) begin fails++; $display("FAIL stall_resp got cyc %0d data %h exp 9 00000001", r_cyc, r_data); end
  endtask
  task automatic test_addr_wrap();
    run_req(1'b0, 3'b000, 32'hFFFFFFF0, 32'h14, 32'h0, 5'd1, 0, 2, 32'h0);
    tests++; if (o_addr !== 25'h4) begin fails++; $display("FAIL wrap_addr got %h exp 0000004", o_addr); end
    run_req(1'b0, 3'b100, 32'h12345678, 32'h0, 32'h0, 5'd1, 0, 2, 32'h0);
    tests++; if (o_addr !== 25'h0345678) begin fails++; $display("FAIL trunc_addr got %h exp 0345678", o_addr); end
  endtask
  task automatic test_back_to_back();
    run_req(1'b0, 3'b010, 32'h0, 32'h10, 32'h0, 5'd8, 0, 2, 32'h0000AAAA);
    tests++; if ({post_valid, post_ready, busy} !== 3'b010) begin fails++; $display("FAIL b2b_idle got %b exp 010", {post_valid, post_ready, busy}); end
    run_req(1'b0, 3'b010, 32'h0, 32'h14, 32'h0, 5'd9, 0, 2, 32'h0000BBBB);
    tests++; if (r_cyc != 4 || r_data !== 32'h0000BBBB || o_addr !== 25'h14) begin fails++; $display("FAIL b2b_second got cyc %0d data %h addr %h exp 4 0000bbbb 14", r_cyc, r_data, o_addr); end
  endtask
  task automatic test_reset_mid();
    seen = 0;
    req_valid = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_base = 32'h300; req_imm = 32'h0; req_rd = 5'd5; mem_valid = 1'b1;
    step(); req_valid = 1'b0; mem_valid = 1'b0;
    step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({busy, mem_enable, resp_valid, req_ready, mem_addr} !== {4'b0001, 25'h0}) begin fails++; $display("FAIL mid_reset got %b %h exp 0001 0", {busy, mem_enable, resp_valid, req_ready}, mem_addr); end
    #1 rst_n = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_valid || busy) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL mid_no_resp got %0d exp 0", seen); end
    run_req(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 0, 2, 32'h00000055);
    tests++; if (r_cyc != 4 || r_data !== 32'h55 || o_addr !== 25'h104) begin fails++; $display("FAIL mid_next got cyc %0d data %h addr %h exp 4 00000055 104", r_cyc, r_data, o_addr); end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_misalign();
    test_illegal();
    test_stall();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Executes RV32I load and store instructions for the core. Sits between the instruction decoder/ALU stage and the data port of the SDRAM controller. Computes the effective address, checks alignment, and issues one access on the data port. Returns load results sign- or zero-extended for register-file writeback, and holds the core stalled while an access is in flight.

## Interface
Parameters:
- ADDR_W, 25, width of the memory address driven to the SDRAM data port
- (none else)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  core presents a load/store
- req_ready  out  1  LSU can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- req_base  in  32  rs1 value
- req_imm  in  32  sign-extended immediate
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  destination register (loads)
- resp_valid  out  1  one-cycle completion pulse
- resp_we  out  1  register-file write enable; high with resp_valid for successful loads with rd≠0
- resp_rd  out  5  destination register
- resp_data  out  32  extended load data
- resp_err  out  1  misaligned access, or unsupported funct3; high with resp_valid
- busy  out  1  state ≠ IDLE
- mem_enable  out  1  one-cycle access request to the data port
- mem_rw  out  1  1 = read, 0 = write
- mem_oplen  out  2  00 byte, 01 half, 10 word
- mem_addr  out  ADDR_W  effective address, low ADDR_W bits
- mem_wdata  out  32  store data, right-aligned, unused upper bits zero
- mem_valid  in  1  data port idle/complete; read data valid on the completing cycle
- mem_rdata  in  32  read data, right-aligned

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields.
  - Compute ea = req_base + req_imm (mod 2^32).
  - Go to ISSUE, or to RESP with error if the check fails.
- Check:
  - funct3 not in the legal set → error. Stores with func3[2]=1 are illegal.
  - LH/LHU/SH with ea[0]=1 → misaligned.
  - LW/SW with ea[1:0]≠0 → misaligned.
- ISSUE:
  - While mem_valid=0, hold and keep mem_enable=0.
  - When mem_valid=1, assert mem_enable for exactly one cycle with mem_rw/mem_oplen/mem_addr/mem_wdata, then go to WAIT.
- WAIT:
  - The first cycle in WAIT ignores mem_valid (controller acceptance latency).
  - Afterwards, the first cycle with mem_valid=1 completes the access. Capture mem_rdata, go to RESP.
- RESP:
  - resp_valid=1 for one cycle, then go to IDLE.
  - Loads: LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW passthrough.
  - Stores: resp_we=0, resp_data=0.
- Outputs are registered and hold their last value outside the relevant states. resp_valid, resp_we and mem_enable are 0 except as stated.

## Timing
- Reset values: all outputs 0 except req_ready=1. State=IDLE.
- Reset asserted mid-access drops mem_enable, resp_valid and busy asynchronously. No response is generated for the aborted request.
- Latency with an immediately idle port and controller completion after N cycles in WAIT: accept at cycle 0, mem_enable at cycle 1, resp_valid at cycle 2+N. Minimum N=2, so minimum latency is 4 cycles.
- Error path: accept at cycle 0, resp_valid at cycle 1, no mem_enable.
- req_valid while busy is ignored. A back-to-back request is accepted in the cycle after resp_valid.

## Configuration
- LOAD_STORE_UNIT_MISALIGN_TRAP_EN defined: misaligned accesses produce resp_err, and no memory access is issued.
- Undefined: alignment is forced by clearing ea[0] (half) or ea[1:0] (word). The access proceeds normally with resp_err=0. Illegal funct3 still errors.

## Structure
- Package defs holds:
  - lsu_state_t enum
  - OPLEN_BYTE/HALF/WORD constants
  - funct3 localparams F3_LB…F3_LHU
- One combinational sub-module, lsu_extend: funct3 + raw 32-bit data → extended result.
- The FSM, address check and port drive live in load_store_unit.

## Test plan
- LW with base 0x100, imm 0x4, mem_rdata 0xDEADBEEF → mem_addr 0x104, oplen 10, rw=1; resp_data 0xDEADBEEF, resp_we=1.
- LB at 0x203 with rdata 0x00000080 → resp_data 0xFFFFFF80; LBU with the same data → 0x00000080.
- SH with base 0x10, imm −2, wdata 0x12345678 → mem_addr 0x0E, oplen 01, rw=0, mem_wdata 0x00005678; resp_we=0.
- LW at 0x102:
  - With the macro: resp_err=1 at cycle 1, no mem_enable.
  - Without the macro: mem_addr 0x100.
- mem_valid held low for 5 cycles in ISSUE, then high → a single mem_enable pulse, issued only after mem_valid rises.
- rst_n pulled low during WAIT → all outputs reset immediately; no resp_valid; the next request completes normally.
